move_select: RTL and testbench

// - Downstream consumer of all_moves: walks the generated move list and scores each

---
 rtl/move_select.sv | 207 ++++++++++++++++++++
 tb/tb_move_select.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_select.sv
// move_select: walks the all_moves list, scores every board by material balance
// (one rank per cycle), keeps the best move for the side to move, then pulses
// clear_moves to release all_moves and finally pulses select_done.
// Optional feature: define MOVE_SELECT_CENTRE_BONUS_EN to add +10 for a white
// pawn and -10 for a black pawn standing on d4/e4/d5/e5.
// Handshake: moves_ready is a level; a list is accepted only from IDLE and only
// after moves_ready has been seen low at least once since the previous accept.
// clear_moves and select_done are registered one-cycle pulses.

`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 64
`endif
`ifndef EMPTY_POSN
`define EMPTY_POSN 0
`define WHITE_PAWN 1
`define WHITE_KNIT 2
`define WHITE_BISH 3
`define WHITE_ROOK 4
`define WHITE_QUEN 5
`define WHITE_KING 6
`define BLACK_PAWN 9
`define BLACK_KNIT 10
`define BLACK_BISH 11
`define BLACK_ROOK 12
`define BLACK_QUEN 13
`define BLACK_KING 14
`endif

module move_select #(
   parameter int PIECE_WIDTH        = `PIECE_BITS,
   parameter int SIDE_WIDTH         = PIECE_WIDTH * 8,
   parameter int BOARD_WIDTH        = PIECE_WIDTH * 64,
   parameter int MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS),
   parameter int EVAL_WIDTH         = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                moves_ready,
   input  logic [MAX_POSITIONS_LOG2-1:0]       move_count,
   input  logic [BOARD_WIDTH-1:0]              board_out,
   input  logic                                white_to_move_out,
   output logic [MAX_POSITIONS_LOG2-1:0]       move_index,
   output logic                                clear_moves,
   output logic                                best_valid,
   output logic [MAX_POSITIONS_LOG2-1:0]       best_index,
   output logic signed [EVAL_WIDTH-1:0]        best_score,
   output logic [BOARD_WIDTH-1:0]              best_board,
   output logic                                select_done
);

   localparam logic [PIECE_WIDTH-1:0] W_PAWN = PIECE_WIDTH'(`WHITE_PAWN);
   localparam logic [PIECE_WIDTH-1:0] W_KNIT = PIECE_WIDTH'(`WHITE_KNIT);
   localparam logic [PIECE_WIDTH-1:0] W_BISH = PIECE_WIDTH'(`WHITE_BISH);
   localparam logic [PIECE_WIDTH-1:0] W_ROOK = PIECE_WIDTH'(`WHITE_ROOK);
   localparam logic [PIECE_WIDTH-1:0] W_QUEN = PIECE_WIDTH'(`WHITE_QUEN);
   localparam logic [PIECE_WIDTH-1:0] B_PAWN = PIECE_WIDTH'(`BLACK_PAWN);
   localparam logic [PIECE_WIDTH-1:0] B_KNIT = PIECE_WIDTH'(`BLACK_KNIT);
   localparam logic [PIECE_WIDTH-1:0] B_BISH = PIECE_WIDTH'(`BLACK_BISH);
   localparam logic [PIECE_WIDTH-1:0] B_ROOK = PIECE_WIDTH'(`BLACK_ROOK);
   localparam logic [PIECE_WIDTH-1:0] B_QUEN = PIECE_WIDTH'(`BLACK_QUEN);

   typedef enum logic [2:0] {
      IDLE, ADDR, WAIT, EVAL, CMP, CLR, CLRW, DONE
   } state_t;

   state_t                          state;
   state_t                          state_next;
   logic                            clear_next;
   logic                            done_next;
   logic [2:0]                      rank_cnt;
   logic signed [EVAL_WIDTH-1:0]    acc;
   logic signed [EVAL_WIDTH-1:0]    rank_sum;
   logic [SIDE_WIDTH-1:0]           rank_bits;
   logic                            side;
   logic                            armed;
   logic [MAX_POSITIONS_LOG2:0]     idx_next;
   logic                            more_moves;
   logic                            better;

   // Material value of one square; KING and EMPTY fall through to zero.
   function automatic logic signed [EVAL_WIDTH-1:0] piece_value(input logic [PIECE_WIDTH-1:0] p);
      case (p)
         W_PAWN:  return EVAL_WIDTH'(100);
         W_KNIT:  return EVAL_WIDTH'(300);
         W_BISH:  return EVAL_WIDTH'(300);
         W_ROOK:  return EVAL_WIDTH'(500);
         W_QUEN:  return EVAL_WIDTH'(900);
         B_PAWN:  return EVAL_WIDTH'(-100);
         B_KNIT:  return EVAL_WIDTH'(-300);
         B_BISH:  return EVAL_WIDTH'(-300);
         B_ROOK:  return EVAL_WIDTH'(-500);
         B_QUEN:  return EVAL_WIDTH'(-900);
         default: return '0;
      endcase
   endfunction

   // Score of the rank currently addressed by rank_cnt.
   always_comb begin
      rank_bits = board_out[32'(rank_cnt) * SIDE_WIDTH +: SIDE_WIDTH];
      rank_sum  = '0;
      for (int c = 0; c < 8; c++) begin
         rank_sum = rank_sum + piece_value(rank_bits[c * PIECE_WIDTH +: PIECE_WIDTH]);
`ifdef MOVE_SELECT_CENTRE_BONUS_EN
         if ((rank_cnt == 3'd3 || rank_cnt == 3'd4) && (c == 3 || c == 4)) begin
            if (rank_bits[c * PIECE_WIDTH +: PIECE_WIDTH] == W_PAWN)
               rank_sum = rank_sum + EVAL_WIDTH'(10);
            else if (rank_bits[c * PIECE_WIDTH +: PIECE_WIDTH] == B_PAWN)
               rank_sum = rank_sum - EVAL_WIDTH'(10);
         end
`endif
      end
   end

   // Scan bookkeeping: another move pending, and whether this board beats the best.
   always_comb begin
      idx_next   = {1'b0, move_index} + {{MAX_POSITIONS_LOG2{1'b0}}, 1'b1};
      more_moves = idx_next < {1'b0, move_count};
      better     = (move_index == '0) || (side && (acc > best_score)) ||
                   (!side && (acc < best_score));
   end

   // State register plus the registered pulse outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         clear_moves <= 1'b0;
         select_done <= 1'b0;
      end else begin
         state       <= state_next;
         clear_moves <= clear_next;
         select_done <= done_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (moves_ready && armed)
                     state_next = (move_count == '0) ? CLR : ADDR;
         ADDR:    state_next = WAIT;
         WAIT:    state_next = EVAL;
         EVAL:    if (rank_cnt == 3'd7) state_next = CMP;
         CMP:     state_next = more_moves ? ADDR : CLR;
         CLR:     state_next = CLRW;
         CLRW:    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode: pulses are registered, so they appear one cycle after the state.
   always_comb begin
      clear_next = (state == CLR);
      done_next  = (state == DONE);
   end

   // Datapath: index walk, rank accumulator, re-arm flag and best-move capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         move_index <= '0;
         rank_cnt   <= '0;
         acc        <= '0;
         side       <= 1'b0;
         armed      <= 1'b1;
         best_valid <= 1'b0;
         best_index <= '0;
         best_score <= '0;
         best_board <= '0;
      end else begin
         case (state)
            IDLE: begin
               move_index <= '0;
               if (!moves_ready) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  armed <= 1'b0;
                  if (move_count == '0) best_valid <= 1'b0;
                  else                  side       <= white_to_move_out;
               end
            end
            WAIT: begin
               acc      <= '0;
               rank_cnt <= '0;
            end
            EVAL: begin
               acc      <= acc + rank_sum;
               rank_cnt <= rank_cnt + 3'd1;
            end
            CMP: begin
               if (better) begin
                  best_valid <= 1'b1;
                  best_index <= move_index;
                  best_score <= acc;
                  best_board <= board_out;
               end
               if (more_moves) move_index <= idx_next[MAX_POSITIONS_LOG2-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_move_select.sv
// Bench for move_select: a one-cycle-latency RAM model stands in for all_moves,
// a whole-board material model predicts each scan's result into the expected
// queues, and a monitor pops and compares on every select_done pulse.
`timescale 1ns/1ps

`ifndef EMPTY_POSN
`define EMPTY_POSN 0
`define WHITE_PAWN 1
`define WHITE_KNIT 2
`define WHITE_BISH 3
`define WHITE_ROOK 4
`define WHITE_QUEN 5
`define WHITE_KING 6
`define BLACK_PAWN 9
`define BLACK_KNIT 10
`define BLACK_BISH 11
`define BLACK_ROOK 12
`define BLACK_QUEN 13
`define BLACK_KING 14
`endif

module tb_move_select;
  localparam int PW = 4;
  localparam int BW = PW * 64;
  localparam int IW = 6;
  localparam int EW = 16;
  localparam logic [PW-1:0] WP = PW'(`WHITE_PAWN);
  localparam logic [PW-1:0] WQ = PW'(`WHITE_QUEN);
  localparam logic [PW-1:0] WK = PW'(`WHITE_KING);
  localparam logic [PW-1:0] BP = PW'(`BLACK_PAWN);
  localparam logic [PW-1:0] BQ = PW'(`BLACK_QUEN);
  localparam logic [PW-1:0] BK = PW'(`BLACK_KING);

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                 moves_ready = 1'b0;
  logic [IW-1:0]        move_count = '0;
  logic [BW-1:0]        board_out = '0;
  logic                 white_to_move_out = 1'b0;
  logic [IW-1:0]        move_index;
  logic                 clear_moves;
  logic                 best_valid;
  logic [IW-1:0]        best_index;
  logic signed [EW-1:0] best_score;
  logic [BW-1:0]        best_board;
  logic                 select_done;

  move_select dut (
    .clk(clk), .reset(reset), .moves_ready(moves_ready), .move_count(move_count),
    .board_out(board_out), .white_to_move_out(white_to_move_out),
    .move_index(move_index), .clear_moves(clear_moves), .best_valid(best_valid),
    .best_index(best_index), .best_score(best_score), .best_board(best_board),
    .select_done(select_done)
  );

  // all_moves list RAM: one cycle read latency
  logic [BW-1:0] mem [0:63];
  always @(posedge clk) board_out <= mem[move_index];

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic          exp_valid_q[$];
  logic [IW-1:0] exp_index_q[$];
  logic [EW-1:0] exp_score_q[$];
  logic [BW-1:0] exp_board_q[$];
  logic          m_valid = 1'b0;
  logic [IW-1:0] m_index = '0;
  logic [EW-1:0] m_score = '0;
  logic [BW-1:0] m_board = '0;

  int lat, clr_cnt, clr_at;
  bit timed_out;

  function automatic int value_of(input logic [PW-1:0] p);
    case (p)
      PW'(`WHITE_PAWN): return 100;
      PW'(`WHITE_KNIT): return 300;
      PW'(`WHITE_BISH): return 300;
      PW'(`WHITE_ROOK): return 500;
      PW'(`WHITE_QUEN): return 900;
      PW'(`BLACK_PAWN): return -100;
      PW'(`BLACK_KNIT): return -300;
      PW'(`BLACK_BISH): return -300;
      PW'(`BLACK_ROOK): return -500;
      PW'(`BLACK_QUEN): return -900;
      default:          return 0;
    endcase
  endfunction

  function automatic int eval_board(input logic [BW-1:0] b);
    int s = 0;
    for (int sq = 0; sq < 64; sq++) begin
      logic [PW-1:0] p = b[sq*PW +: PW];
      s += value_of(p);
`ifdef MOVE_SELECT_CENTRE_BONUS_EN
      if ((sq / 8 == 3 || sq / 8 == 4) && (sq % 8 == 3 || sq % 8 == 4)) begin
        if (p == WP) s += 10;
        if (p == BP) s -= 10;
      end
`endif
    end
    return s;
  endfunction

  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r, input int c,
                                        input logic [PW-1:0] p);
    logic [BW-1:0] o = b;
    o[(r*8 + c)*PW +: PW] = p;
    return o;
  endfunction

  // predict the scan over mem[0..n-1] and push the expected result
  task automatic expect_scan(input int n, input logic side);
    int best = 0;
    int bi = 0;
    for (int i = 0; i < n; i++) begin
      int s = eval_board(mem[i]);
      if (i == 0 || (side && s > best) || (!side && s < best)) begin
        best = s;
        bi = i;
      end
    end
    if (n > 0) begin
      m_valid = 1'b1;
      m_index = IW'(bi);
      m_score = EW'(best);
      m_board = mem[bi];
    end else begin
      m_valid = 1'b0;
    end
    exp_valid_q.push_back(m_valid);
    exp_index_q.push_back(m_index);
    exp_score_q.push_back(m_score);
    exp_board_q.push_back(m_board);
  endtask

  // driver: present a list, count cycles from the sampling edge to select_done
  task automatic run_scan(input int n, input logic side, input bit hold);
    @(negedge clk);
    move_count = IW'(n);
    white_to_move_out = side;
    moves_ready = 1'b1;
    @(posedge clk);
    lat = 0; clr_cnt = 0; clr_at = -1; timed_out = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      lat++;
      if (!hold && lat == 4) moves_ready = 1'b0;
      if (clear_moves) begin clr_cnt++; clr_at = lat; end
      if (select_done) begin timed_out = 1'b0; break; end
    end
    if (timed_out) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: select_done not seen within 1000 cycles (n=%0d)", n);
      exp_valid_q.delete(); exp_index_q.delete(); exp_score_q.delete(); exp_board_q.delete();
    end
    if (!hold) moves_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    @(negedge clk); moves_ready = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  // scoreboard monitor: compare on every select_done pulse
  always @(negedge clk) begin
    if (!reset && select_done === 1'b1) begin
      n_checks++;
      if (exp_valid_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: select_done=1 required no pulse");
      end else begin
        logic ev; logic [IW-1:0] ei; logic [EW-1:0] es; logic [BW-1:0] eb;
        ev = exp_valid_q.pop_front(); ei = exp_index_q.pop_front();
        es = exp_score_q.pop_front(); eb = exp_board_q.pop_front();
        if (best_valid !== ev) begin
          n_fail++; $display("FAIL sb_valid: got %0b required %0b", best_valid, ev);
        end
        n_checks++;
        if (best_index !== ei) begin
          n_fail++; $display("FAIL sb_index: got %0d required %0d", best_index, ei);
        end
        n_checks++;
        if (best_score !== es) begin
          n_fail++; $display("FAIL sb_score: got %0d required %0d", best_score, $signed(es));
        end
        n_checks++;
        if (best_board !== eb) begin
          n_fail++; $display("FAIL sb_board: got %h required %h", best_board, eb);
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({move_index, clear_moves, best_valid, best_index, select_done} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got idx=%0d clr=%0b v=%0b bi=%0d done=%0b required all 0",
                         move_index, clear_moves, best_valid, best_index, select_done);
    end
    n_checks++;
    if (best_score !== '0 || best_board !== '0) begin
      n_fail++; $display("FAIL reset_best: got score=%0d board=%h required 0", best_score, best_board);
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (clear_moves !== 1'b0 || select_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_quiet: got clr=%0b done=%0b required 0 0", clear_moves, select_done);
    end
  endtask

  task automatic test_empty_list;
    expect_scan(0, 1'b1);
    run_scan(0, 1'b1, 1'b0);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL empty_latency: got %0d required 3", lat); end
    n_checks++;
    if (clr_cnt !== 1 || clr_at !== lat - 2) begin
      n_fail++; $display("FAIL empty_clear: got count=%0d at=%0d required count=1 at=%0d", clr_cnt, clr_at, lat - 2);
    end
    idle_cycles(2);
  endtask

  // WQ a1, BQ e5, BP e7
  function automatic logic [BW-1:0] root_pos();
    logic [BW-1:0] b = '0;
    b = put(b, 0, 0, WQ);
    b = put(b, 4, 4, BQ);
    b = put(b, 6, 4, BP);
    return b;
  endfunction

  task automatic test_white_capture;
    logic [BW-1:0] b = root_pos();
    mem[0] = put(put(b, 0, 0, '0), 1, 0, WQ);   // Qa2
    mem[1] = put(put(b, 0, 0, '0), 4, 4, WQ);   // Qxe5
    mem[2] = put(put(b, 0, 0, '0), 0, 1, WQ);   // Qb1
    expect_scan(3, 1'b1);
    run_scan(3, 1'b1, 1'b0);
    n_checks++;
    if (lat !== 36) begin n_fail++; $display("FAIL white_latency: got %0d required 36", lat); end
    n_checks++;
    if (best_score !== 16'sd800) begin n_fail++; $display("FAIL white_score: got %0d required 800", best_score); end
    n_checks++;
    if (best_board[(4*8+4)*PW +: PW] !== WQ) begin
      n_fail++; $display("FAIL white_e5: got %0d required %0d", best_board[(4*8+4)*PW +: PW], WQ);
    end
    n_checks++;
    if (clr_cnt !== 1 || clr_at !== lat - 2) begin
      n_fail++; $display("FAIL white_clear: got count=%0d at=%0d required count=1 at=%0d", clr_cnt, clr_at, lat - 2);
    end
    idle_cycles(2);
  endtask

  task automatic test_black_capture;
    logic [BW-1:0] b = root_pos();
    mem[0] = put(put(b, 4, 4, '0), 3, 4, BQ);   // Qe4
    mem[1] = put(put(b, 4, 4, '0), 0, 0, BQ);   // Qxa1
    mem[2] = put(put(b, 6, 4, '0), 5, 4, BP);   // e6
    expect_scan(3, 1'b0);
    run_scan(3, 1'b0, 1'b0);
    n_checks++;
    if (best_index !== IW'(1)) begin n_fail++; $display("FAIL black_index: got %0d required 1", best_index); end
    n_checks++;
    if (best_board[0 +: PW] !== BQ) begin
      n_fail++; $display("FAIL black_a1: got %0d required %0d", best_board[0 +: PW], BQ);
    end
    idle_cycles(2);
  endtask

  task automatic test_ties;
    logic [BW-1:0] b;
    for (int i = 0; i < 4; i++) begin
      b = '0;
      b = put(b, 0, i, WK);
      b = put(b, 7, 7 - i, BK);
      mem[i] = b;
    end
    expect_scan(4, 1'b1);
    run_scan(4, 1'b1, 1'b0);
    n_checks++;
    if (lat !== 47) begin n_fail++; $display("FAIL tie_latency: got %0d required 47", lat); end
    n_checks++;
    if (best_index !== '0) begin n_fail++; $display("FAIL tie_index: got %0d required 0", best_index); end
    idle_cycles(2);
  endtask

  task automatic test_rearm;
    int extra = 0;
    expect_scan(4, 1'b0);
    run_scan(4, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (clear_moves || select_done || move_index != '0) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL rearm_restart: got %0d active cycles required 0", extra); end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_scan;
    int clr_seen = 0;
    logic [BW-1:0] b = root_pos();
    mem[0] = put(put(b, 0, 0, '0), 1, 0, WQ);
    mem[1] = put(put(b, 0, 0, '0), 4, 4, WQ);
    mem[2] = put(put(b, 0, 0, '0), 0, 1, WQ);
    @(negedge clk);
    move_count = IW'(3); white_to_move_out = 1'b1; moves_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (clear_moves) clr_seen++;
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({move_index, clear_moves, best_valid, best_index, select_done} !== '0 ||
        best_score !== '0 || best_board !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got idx=%0d v=%0b bi=%0d score=%0d required all 0",
                         move_index, best_valid, best_index, best_score);
    end
    m_valid = 1'b0; m_index = '0; m_score = '0; m_board = '0;
    moves_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (clear_moves) clr_seen++;
    end
    n_checks++;
    if (clr_seen !== 0) begin n_fail++; $display("FAIL midreset_clear: got %0d pulses required 0", clr_seen); end
    expect_scan(3, 1'b1);
    run_scan(3, 1'b1, 1'b0);
    n_checks++;
    if (lat !== 36) begin n_fail++; $display("FAIL midreset_restart_latency: got %0d required 36", lat); end
    idle_cycles(2);
  endtask

  task automatic test_random;
    logic [PW-1:0] codes [12] = '{1, 2, 3, 4, 5, 6, 9, 10, 11, 12, 13, 14};
    for (int t = 0; t < 5; t++) begin
      int n = $urandom_range(1, 6);
      logic side = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        int placed = 0;
        mem[i] = '0;
        for (int sq = 0; sq < 64; sq++) begin
          if (placed < 20 && $urandom_range(0, 5) == 0) begin
            mem[i][sq*PW +: PW] = codes[$urandom_range(0, 11)];
            placed++;
          end
        end
      end
      expect_scan(n, side);
      run_scan(n, side, 1'($urandom_range(0, 1)));
      n_checks++;
      if (lat !== 11 * n + 3) begin
        n_fail++; $display("FAIL random_latency: got %0d required %0d", lat, 11 * n + 3);
      end
      idle_cycles(2);
    end
  endtask

  task automatic test_centre_bonus;
    int exp_idx;
    mem[0] = put('0, 2, 4, WP);   // e2e3
    mem[1] = put('0, 3, 4, WP);   // e2e4
`ifdef MOVE_SELECT_CENTRE_BONUS_EN
    exp_idx = 1;
`else
    exp_idx = 0;
`endif
    expect_scan(2, 1'b1);
    run_scan(2, 1'b1, 1'b0);
    n_checks++;
    if (best_index !== IW'(exp_idx)) begin
      n_fail++; $display("FAIL centre_index: got %0d required %0d", best_index, exp_idx);
    end
    idle_cycles(2);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_empty_list();
    test_white_capture();
    test_black_capture();
    test_ties();
    test_rearm();
    test_reset_mid_scan();
    test_random();
    test_centre_bonus();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_valid_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d pending required 0", exp_valid_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
